// File: rtl/serial_nibble_adder.sv
// Multi-cycle wide adder controller: streams operand nibbles LSB-first to an external 4-bit adder and assembles the sum.
// Optional signed-overflow output enabled by defining SERIAL_NIBBLE_ADDER_OVF_EN.
module serial_nibble_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] in_a,
  input  logic [4*NIBBLES-1:0] in_b,
  input  logic                 in_cin,
  output logic [3:0]           add_a,
  output logic [3:0]           add_b,
  output logic                 add_cin,
  input  logic [3:0]           add_sum,
  input  logic                 add_cout,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] out_sum,
  output logic                 out_cout,
  output logic                 out_ovf
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_next;
  logic [W-1:0]   a_reg, b_reg, sum_reg, sum_shift;
  logic           carry_reg, cout_reg;
  logic [CW-1:0]  cnt;
  logic           last;

  assign last = (cnt == CW'(NIBBLES - 1));

  // New nibble enters at the top; after NIBBLES shifts nibble 0 sits at the bottom.
  generate
    if (NIBBLES == 1) begin : g_single
      assign sum_shift = add_sum;
    end else begin : g_multi
      assign sum_shift = {add_sum, sum_reg[W-1:4]};
    end
  endgenerate

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    add_a      = 4'd0;
    add_b      = 4'd0;
    add_cin    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        add_a   = a_reg[3:0];
        add_b   = b_reg[3:0];
        add_cin = carry_reg;
        if (last) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      cnt       <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= in_a;
            b_reg     <= in_b;
            carry_reg <= in_cin;
            cnt       <= '0;
          end
        end
        RUN: begin
          sum_reg   <= sum_shift;
          carry_reg <= add_cout;
          a_reg     <= a_reg >> 4;
          b_reg     <= b_reg >> 4;
          cnt       <= cnt + 1'b1;
          if (last) cout_reg <= add_cout;
        end
        default: ;
      endcase
    end
  end

  assign out_sum  = sum_reg;
  assign out_cout = cout_reg;

`ifdef SERIAL_NIBBLE_ADDER_OVF_EN
  logic ovf_reg;

  // Overflow is judged on the MSB nibble only: operand signs agree but sum sign differs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_reg <= 1'b0;
    end else if (state == RUN && last) begin
      ovf_reg <= (add_a[3] == add_b[3]) && (add_sum[3] != add_a[3]);
    end else if (state == DONE && out_ready) begin
      ovf_reg <= 1'b0;
    end
  end

  assign out_ovf = ovf_reg;
`else
  assign out_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_nibble_adder.sv
// Directed-vector bench for serial_nibble_adder with a behavioural 4-bit adder stage attached.
module tb_serial_nibble_adder;
  localparam int NIBBLES = 4;
  localparam int W = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_cin = 1'b0;
  logic [3:0]   add_a, add_b, add_sum;
  logic         add_cin, add_cout;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_sum;
  logic         out_cout, out_ovf;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int accept_cyc = 0;

  serial_nibble_adder #(.NIBBLES(NIBBLES)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
  );

  // External combinational 4-bit adder stage
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef SERIAL_NIBBLE_ADDER_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one operand pair; leaves the bench in the first RUN cycle.
  task automatic start_txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    check("in_ready_idle", {31'd0, in_ready}, 32'd1);
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
    step();
    accept_cyc = cyc;
    in_valid = 1'b0;
    in_a = '0; in_b = '0; in_cin = 1'b0;
    check("run_add_a", {28'd0, add_a}, {28'd0, a[3:0]});
    check("run_add_b", {28'd0, add_b}, {28'd0, b[3:0]});
    check("run_add_cin", {31'd0, add_cin}, {31'd0, cin});
    check("in_ready_run", {31'd0, in_ready}, 32'd0);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    check("done_timeout", {31'd0, out_valid}, 32'd1);
    check("latency", cyc - accept_cyc, NIBBLES);
  endtask

  task automatic check_result(input string name, input logic [W-1:0] es, input logic ec, input logic eo);
    check({name, "_sum"}, {16'd0, out_sum}, {16'd0, es});
    check({name, "_cout"}, {31'd0, out_cout}, {31'd0, ec});
    check({name, "_ovf"}, {31'd0, out_ovf}, {31'd0, eo});
    $display("txn %s: sum=0x%04h cout=%0d ovf=%0d (exp 0x%04h %0d %0d)",
             name, out_sum, out_cout, out_ovf, es, ec, eo);
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("valid_drop", {31'd0, out_valid}, 32'd0);
    check("in_ready_back", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic run_txn(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic [W-1:0] es, input logic ec, input logic eo);
    start_txn(a, b, cin);
    wait_done();
    check_result(name, es, ec, eo);
    release_result();
  endtask

  initial begin
    #2;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_sum", {16'd0, out_sum}, 32'd0);
    check("rst_out_cout", {31'd0, out_cout}, 32'd0);
    check("rst_add", {23'd0, add_a, add_b, add_cin}, 32'd0);
    step();
    rst_n = 1'b1;
    step();

    run_txn("t1", 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
    run_txn("t2", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_txn("t3", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, OVF_ON);

    // Carry-in only reaches the adder stage in the first RUN cycle
    start_txn(16'h0000, 16'h0000, 1'b1);
    step();
    check("cin_second_cycle", {31'd0, add_cin}, 32'd0);
    wait_done();
    check_result("t4", 16'h0001, 1'b0, 1'b0);
    release_result();

    // Back-pressure: DONE holds through out_ready low and ignores in_valid
    start_txn(16'h1111, 16'h2222, 1'b0);
    wait_done();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_a = 16'hAAAA; in_b = 16'h5555;
      step();
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_sum", {16'd0, out_sum}, 32'h3333);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0; in_a = '0; in_b = '0;
    check_result("t5", 16'h3333, 1'b0, 1'b0);
    release_result();
    step();
    check("no_stray_accept", {31'd0, in_ready}, 32'd1);

    // Reset asserted in the second RUN cycle
    start_txn(16'h1234, 16'h4321, 1'b1);
    step();
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_out_sum", {16'd0, out_sum}, 32'd0);
    check("midrst_add", {23'd0, add_a, add_b, add_cin}, 32'd0);
    check("midrst_cout_ovf", {30'd0, out_cout, out_ovf}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      check("midrst_no_valid", {31'd0, out_valid}, 32'd0);
    end
    rst_n = 1'b1;
    step();
    run_txn("t6", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
